quadrature_generator: RTL and testbench

// - Quadrature A/B waveform generator: the transmit side of the servo encoder interface.
// - Takes step commands (direction, edge count, edge period) from the PS over a valid/ready handshake.
// - Emits clean 2-bit Gray-code A/B edges at the commanded rate and tracks the emitted position.
// - Used as an encoder emulator for HIL tests of the decoder and the homing sequence, and as a step source.

---
 rtl/quad_gen_pkg.sv | 9 +
 rtl/quad_rate_timer.sv | 26 ++
 rtl/quadrature_generator.sv | 90 +++++++++
 tb/tb_quadrature_generator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/quad_gen_pkg.sv
// quad_gen_pkg: shared state encoding, Gray step tables and widths for the quadrature generator.
package quad_gen_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int POS_W = 16;
   localparam int PERIOD_W = 16;
   // Indexed by the current {A,B}; forward runs 00->01->11->10, backward the reverse.
   localparam logic [3:0][1:0] FWD_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};
   localparam logic [3:0][1:0] BWD_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};
endpackage

// File: rtl/quad_rate_timer.sv
// quad_rate_timer: loadable edge-rate down-counter; tick is high while the count is zero.
module quad_rate_timer
   import quad_gen_pkg::*;
#(
   parameter int MIN_PERIOD = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);
   logic [PERIOD_W-1:0] eff, count, clamped;
   assign clamped = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
   assign tick = count == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         eff   <= '0;
         count <= '0;
      end else if (load) begin
         eff   <= clamped;
         count <= clamped - PERIOD_W'(1);
      end else if (en)
         count <= tick ? eff - PERIOD_W'(1) : count - PERIOD_W'(1);
endmodule

// File: rtl/quadrature_generator.sv
// quadrature_generator: commanded A/B quadrature edge source with position tracking.
// Defining QUAD_GEN_INDEX_EN adds the Z index output and its edge counter.
module quadrature_generator
   import quad_gen_pkg::*;
#(
   parameter int POS_INIT   = 32000,
   parameter int POS_MAX    = 64000,
   parameter int MIN_PERIOD = 4
`ifdef QUAD_GEN_INDEX_EN
   , parameter int INDEX_EDGES = 400
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_dir,
   input  logic [PERIOD_W-1:0] cmd_steps,
   input  logic [PERIOD_W-1:0] cmd_period,
   input  logic                abort,
   output logic                A,
   output logic                B,
   output logic                busy,
   output logic                done,
   output logic [POS_W-1:0]    position
`ifdef QUAD_GEN_INDEX_EN
   , output logic              Z
`endif
);
   state_t state;
   logic dir, tick, step;
   logic [PERIOD_W-1:0] remaining;
   logic [1:0] ab, ab_next;
   logic [POS_W-1:0] pos_next;
   assign {A, B} = ab;
   assign step = busy && !abort && remaining != '0 && tick;
   assign ab_next = dir ? FWD_NEXT[ab] : BWD_NEXT[ab];
   assign pos_next = dir ? (position == POS_W'(POS_MAX - 1) ? '0 : position + POS_W'(1))
                         : (position == '0 ? POS_W'(POS_MAX - 1) : position - POS_W'(1));
   quad_rate_timer #(.MIN_PERIOD(MIN_PERIOD)) timer (
      .clk(clk), .rst(rst), .load(cmd_valid && cmd_ready), .en(busy),
      .period(cmd_period), .tick(tick)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir       <= 1'b0;
         remaining <= '0;
         ab        <= 2'b00;
         position  <= POS_W'(POS_INIT);
      end else if (state == IDLE) begin
         if (cmd_valid) begin
            state     <= RUN;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            dir       <= cmd_dir;
            remaining <= cmd_steps;
         end
      end else if (state == DONE) begin
         state     <= IDLE;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
      end else if (abort || remaining == '0) begin
         state <= DONE;
         busy  <= 1'b0;
         done  <= 1'b1;
      end else if (step) begin
         ab        <= ab_next;
         position  <= pos_next;
         remaining <= remaining - PERIOD_W'(1);
      end
`ifdef QUAD_GEN_INDEX_EN
   localparam int IDX_W = $clog2(INDEX_EDGES);
   logic [IDX_W-1:0] idx, idx_next;
   assign idx_next = dir ? (idx == IDX_W'(INDEX_EDGES - 1) ? '0 : idx + IDX_W'(1))
                         : (idx == '0 ? IDX_W'(INDEX_EDGES - 1) : idx - IDX_W'(1));
   // Z only changes on an edge, so it stays low after reset until the wheel comes round.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         idx <= '0;
         Z   <= 1'b0;
      end else if (step) begin
         idx <= idx_next;
         Z   <= idx_next == '0 && ab_next == 2'b00;
      end
`endif
endmodule

// File: tb/tb_quadrature_generator.sv
// tb_quadrature_generator: randomized and directed commands checked against an edge-count model.
module tb_quadrature_generator;
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
   logic [15:0] cmd_steps = '0, cmd_period = '0;
   logic cmd_ready, a_o, b_o, busy, done;
   logic cmd_ready2, a2, b2, busy2, done2;
   logic [15:0] position, position2;
`ifdef QUAD_GEN_INDEX_EN
   logic z, z2;
`endif
   int checks = 0, errors = 0;
   int net = 0;
   bit had_edge = 1'b0;
   int gray [4] = '{0, 1, 3, 2};

   always #5 clk = ~clk;

   quadrature_generator dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .A(a_o), .B(b_o),
      .busy(busy), .done(done), .position(position)
`ifdef QUAD_GEN_INDEX_EN
      , .Z(z)
`endif
   );
   quadrature_generator #(.POS_INIT(63998)) dut_wrap (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_dir(cmd_dir),
      .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .position(position2)
`ifdef QUAD_GEN_INDEX_EN
      , .Z(z2)
`endif
   );

   function automatic int md(input int x, input int m);
      return ((x % m) + m) % m;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input int n, input bit he);
      check("ab", int'({a_o, b_o}), gray[md(n, 4)]);
      check("position", int'(position), md(32000 + n, 64000));
      check("position_wrap", int'(position2), md(63998 + n, 64000));
`ifdef QUAD_GEN_INDEX_EN
      check("z", int'(z), int'(he && md(n, 400) == 0));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      net = 0;
      had_edge = 1'b0;
      check_outputs(0, 1'b0);
      check("reset_ready", int'(cmd_ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // a > 0 asserts abort so that it is sampled a clocks after the accept edge.
   task automatic run_cmd(input bit d, input int n, input int p, input int a);
      int eff, end_c, edges, sgn, k;
      eff = p < 4 ? 4 : p;
      sgn = d ? 1 : -1;
      end_c = a > 0 ? a : n * eff + 1;
      edges = 0;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_dir = d;
      cmd_steps = 16'(n);
      cmd_period = 16'(p);
      @(posedge clk);
      #1;
      for (int c = 0; c <= end_c + 1; c++) begin
         edges = c / eff;
         if (edges > n) edges = n;
         if (a > 0 && c >= a && edges > (a - 1) / eff) edges = (a - 1) / eff;
         check_outputs(net + sgn * edges, had_edge || edges > 0);
         check("busy", int'(busy), int'(c < end_c));
         check("done", int'(done), int'(c == end_c));
         check("ready", int'(cmd_ready), int'(c > end_c));
         cmd_valid = (c < end_c - 1) ? 1'($urandom % 2) : 1'b0;
         cmd_dir = 1'($urandom % 2);
         cmd_steps = 16'($urandom);
         abort = (a > 0 && c == a - 1) || c == end_c;
         @(posedge clk);
         #1;
      end
      abort = 1'b0;
      cmd_valid = 1'b0;
      net += sgn * edges;
      had_edge = had_edge || edges > 0;
   endtask

   initial begin
      int n, p, eff, a, k;
      do_reset();
      run_cmd(1'b1, 3, 4, 0);
      run_cmd(1'b0, 2, 4, 0);
      run_cmd(1'b1, 10, 8, 0);
      run_cmd(1'b1, 3, 1, 0);
      run_cmd(1'b0, 0, 5, 0);
      run_cmd(1'b1, 100, 10, 35);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_idle_ready", int'(cmd_ready), 1);
      check("abort_idle_done", int'(done), 0);
      run_cmd(1'b0, 2, 0, 0);
      cmd_valid = 1'b1;
      cmd_dir = 1'b1;
      cmd_steps = 16'd10;
      cmd_period = 16'd4;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_outputs(net + 5, 1'b1);
      rst = 1'b1;
      #1;
      net = 0;
      had_edge = 1'b0;
      check_outputs(0, 1'b0);
      check("midrun_ready", int'(cmd_ready), 1);
      check("midrun_busy", int'(busy), 0);
      check("midrun_done", int'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("post_reset_done", int'(done), 0);
      end
      for (int i = 0; i < 25; i++) begin
         n = $urandom_range(0, 12);
         p = $urandom_range(0, 12);
         eff = p < 4 ? 4 : p;
         a = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n * eff) : 0;
         run_cmd(1'($urandom % 2), n, p, a);
      end
`ifdef QUAD_GEN_INDEX_EN
      do_reset();
      run_cmd(1'b1, 800, 4, 0);
      run_cmd(1'b0, 1, 4, 0);
`endif
      k = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
